// File: rtl/nibble_bus_arbiter.sv
// Two-requester round-robin arbiter that drives the nibble mux select and registers the chosen nibble.
// Defining ARB_TIMEOUT_EN adds a hold counter that preempts a grant after MAX_HOLD contended cycles.
module nibble_bus_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             SEL,
    output logic [WIDTH-1:0] OUT,
    output logic             OUT_VALID
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_prio;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_sel;
    logic             r_valid;
    logic [WIDTH-1:0] r_out;

    logic w_preempt0;
    logic w_preempt1;
    logic w_exit;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_count;

    // A grant is cut short only when the hold limit is reached and the other side is waiting.
    assign w_preempt0 = (r_count == 8'(MAX_HOLD)) && REQ1;
    assign w_preempt1 = (r_count == 8'(MAX_HOLD)) && REQ0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_count <= 8'd0;
        end else if (r_state == IDLE) begin
            r_count <= (REQ0 || REQ1) ? 8'd1 : 8'd0;
        end else if (w_exit) begin
            r_count <= 8'd0;
        end else if (r_count != 8'(MAX_HOLD)) begin
            r_count <= r_count + 8'd1;
        end
    end
`else
    assign w_preempt0 = 1'b0;
    assign w_preempt1 = 1'b0;
`endif

    assign w_exit = ((r_state == GRANT0) && (!REQ0 || w_preempt0)) ||
                    ((r_state == GRANT1) && (!REQ1 || w_preempt1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_prio  <= 1'b0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_sel   <= 1'b0;
            r_valid <= 1'b0;
            r_out   <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (REQ0 && (!REQ1 || !r_prio)) begin
                        r_state <= GRANT0;
                        r_gnt0  <= 1'b1;
                        r_sel   <= 1'b0;
                    end else if (REQ1) begin
                        r_state <= GRANT1;
                        r_gnt1  <= 1'b1;
                        r_sel   <= 1'b1;
                    end
                end
                GRANT0: begin
                    if (REQ0) begin
                        r_out   <= D0;
                        r_valid <= 1'b1;
                    end
                    if (w_exit) begin
                        r_state <= IDLE;
                        r_gnt0  <= 1'b0;
                        r_prio  <= 1'b1;
                    end
                end
                GRANT1: begin
                    if (REQ1) begin
                        r_out   <= D1;
                        r_valid <= 1'b1;
                    end
                    if (w_exit) begin
                        r_state <= IDLE;
                        r_gnt1  <= 1'b0;
                        r_prio  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                end
            endcase
        end
    end

    assign GNT0      = r_gnt0;
    assign GNT1      = r_gnt1;
    assign SEL       = r_sel;
    assign OUT       = r_out;
    assign OUT_VALID = r_valid;

endmodule

// File: tb/tb_nibble_bus_arbiter.sv
// Scoreboard bench for nibble_bus_arbiter; expectations adapt to whether ARB_TIMEOUT_EN is defined.
module tb_nibble_bus_arbiter;

    localparam int WIDTH = 4;
    localparam int HOLD  = 4;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             REQ0;
    logic             REQ1;
    logic [WIDTH-1:0] D0;
    logic [WIDTH-1:0] D1;
    logic             GNT0;
    logic             GNT1;
    logic             SEL;
    logic [WIDTH-1:0] OUT;
    logic             OUT_VALID;

    always #5 CLK = ~CLK;

    nibble_bus_arbiter #(
        .WIDTH   (WIDTH),
        .MAX_HOLD(HOLD)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .REQ0     (REQ0),
        .REQ1     (REQ1),
        .D0       (D0),
        .D1       (D1),
        .GNT0     (GNT0),
        .GNT1     (GNT1),
        .SEL      (SEL),
        .OUT      (OUT),
        .OUT_VALID(OUT_VALID)
    );

    typedef struct packed {
        logic       g0;
        logic       g1;
        logic       sel;
        logic [3:0] out;
        logic       v;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic g0, input logic g1, input logic sel,
                                input logic [3:0] out, input logic v);
        exp_t e;
        e.g0  = g0;
        e.g1  = g1;
        e.sel = sel;
        e.out = out;
        e.v   = v;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Pops the oldest expectation once the DUT has produced the corresponding output cycle.
    task automatic sampleOutputs(input string tag);
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: scoreboard empty", tag);
            return;
        end
        e = expQ.pop_front();
        checkOutput({tag, ".gnt0"},  {7'd0, GNT0},      {7'd0, e.g0});
        checkOutput({tag, ".gnt1"},  {7'd0, GNT1},      {7'd0, e.g1});
        checkOutput({tag, ".sel"},   {7'd0, SEL},       {7'd0, e.sel});
        checkOutput({tag, ".out"},   {4'd0, OUT},       {4'd0, e.out});
        checkOutput({tag, ".valid"}, {7'd0, OUT_VALID}, {7'd0, e.v});
    endtask

    task automatic applyStimulus(input string tag, input logic rst, input logic r0, input logic r1,
                                 input logic [3:0] d0, input logic [3:0] d1, input exp_t e);
        RESET = rst;
        REQ0  = r0;
        REQ1  = r1;
        D0    = d0;
        D1    = d1;
        expQ.push_back(e);
        @(posedge CLK);
        #1;
        sampleOutputs(tag);
    endtask

    initial begin
        exp_t       e;
        int         ph;
        int         blk;
        logic       own;
        logic       g;
        logic [3:0] lastOut;
        logic       lastSel;

        // Reset held with both requesting, then requester 0 wins the first tie.
        applyStimulus("rst1", 1, 1, 1, 4'h1, 4'h2, mk(0, 0, 0, 4'h0, 0));
        applyStimulus("rst2", 1, 1, 1, 4'h1, 4'h2, mk(0, 0, 0, 4'h0, 0));
        applyStimulus("first", 0, 1, 1, 4'h1, 4'h2, mk(1, 0, 0, 4'h0, 0));
        applyStimulus("rel0", 0, 0, 0, 4'h1, 4'h2, mk(0, 0, 0, 4'h0, 0));

        // Single requester streaming three nibbles.
        applyStimulus("single.g", 0, 1, 0, 4'h5, 4'h0, mk(1, 0, 0, 4'h0, 0));
        applyStimulus("single.A", 0, 1, 0, 4'hA, 4'h0, mk(1, 0, 0, 4'hA, 1));
        applyStimulus("single.B", 0, 1, 0, 4'hB, 4'h0, mk(1, 0, 0, 4'hB, 1));
        applyStimulus("single.C", 0, 1, 0, 4'hC, 4'h0, mk(1, 0, 0, 4'hC, 1));
        applyStimulus("single.rel", 0, 0, 0, 4'hD, 4'h0, mk(0, 0, 0, 4'hC, 0));

        // Tie after a GRANT0 release goes to requester 1, then sustained contention.
        for (int t = 0; t < 20; t++) begin
`ifdef ARB_TIMEOUT_EN
            ph  = t % (HOLD + 1);
            blk = t / (HOLD + 1);
            own = ((blk % 2) == 0);
            g   = (ph < HOLD);
            e.g1  = g && own;
            e.g0  = g && !own;
            e.sel = own;
            if (ph == 0) begin
                e.v   = 1'b0;
                e.out = (t == 0) ? 4'hC : (own ? 4'h3 : 4'h7);
            end else begin
                e.v   = 1'b1;
                e.out = own ? 4'h7 : 4'h3;
            end
`else
            e = mk(0, 1, 1, (t == 0) ? 4'hC : 4'h7, (t != 0));
`endif
            applyStimulus($sformatf("cont%0d", t), 0, 1, 1, 4'h3, 4'h7, e);
        end

`ifdef ARB_TIMEOUT_EN
        lastOut = 4'h3;
        lastSel = 1'b0;
`else
        lastOut = 4'h7;
        lastSel = 1'b1;
`endif
        applyStimulus("cont.rel", 0, 0, 0, 4'h3, 4'h7, mk(0, 0, lastSel, lastOut, 0));

        // Reset during the second GRANT1 cycle discards that cycle's nibble.
        applyStimulus("mid.g1", 0, 0, 1, 4'h0, 4'h9, mk(0, 1, 1, lastOut, 0));
        applyStimulus("mid.g2", 0, 0, 1, 4'h0, 4'h9, mk(0, 1, 1, 4'h9, 1));
        applyStimulus("mid.rst", 1, 1, 1, 4'h6, 4'hE, mk(0, 0, 0, 4'h0, 0));
        applyStimulus("mid.after", 0, 1, 1, 4'h6, 4'hE, mk(1, 0, 0, 4'h0, 0));
        applyStimulus("mid.rel", 0, 0, 0, 4'h6, 4'hE, mk(0, 0, 0, 4'h0, 0));

        // Re-grant to the same requester still passes through an idle cycle.
        applyStimulus("re.g", 0, 1, 0, 4'h5, 4'h0, mk(1, 0, 0, 4'h0, 0));
        applyStimulus("re.drop", 0, 0, 0, 4'h6, 4'h0, mk(0, 0, 0, 4'h0, 0));
        applyStimulus("re.g2", 0, 1, 0, 4'h6, 4'h0, mk(1, 0, 0, 4'h0, 0));
        applyStimulus("re.xfer", 0, 1, 0, 4'h5, 4'h0, mk(1, 0, 0, 4'h5, 1));
        applyStimulus("re.rel", 0, 0, 0, 4'h8, 4'h0, mk(0, 0, 0, 4'h5, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
